// File: rtl/morph_edge_stream.sv
// Streaming threshold + 3x3 binary morphology (erode/dilate/gradients) using
// two 1-bit line buffers; one 8-bit result per input pixel in raster order.
module morph_edge_stream #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int CW    = 17
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [7:0]    thr_i,
    input  logic [1:0]    mode_i,
    input  logic          in_valid_i,
    input  logic [7:0]    in_data_i,
    output logic          in_ready_o,
    output logic          out_valid_o,
    output logic [7:0]    out_data_o,
    input  logic          out_ready_i,
    output logic          busy_o,
    output logic          frame_done_o,
    output logic [2:0]    state_o,
    output logic [CW-1:0] pix_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_FLUSH = 3'd2,
        S_DONE  = 3'd3
    } state_t;

    localparam int SRL = 2*IMG_W + 3;
    localparam int FW  = $clog2(IMG_W + 2);
    localparam int CLW = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam logic [FW-1:0]  FILL_N   = FW'(IMG_W + 1);
    localparam logic [CLW-1:0] COL_LAST = CLW'(IMG_W - 1);
    localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0]  N_LAST   = CW'(IMG_W*IMG_H - 1);

    state_t          state_q, state_d;
    logic [7:0]      thr_q;
    logic [1:0]      mode_q;
    logic [SRL-2:0]  win_q;
    logic [SRL-1:0]  win_d;
    logic [FW-1:0]   fill_q, flush_q;
    logic [CLW-1:0]  col_q;
    logic [RW-1:0]   row_q;
    logic [CW-1:0]   in_cnt_q, pix_cnt_q;
    logic            out_valid_q;
    logic [7:0]      out_data_q;

    logic slot_free, in_fire, flush_fire, push, primed, out_hs, new_bit;
    logic up, dn, lf, rt, ero, dil, bw, res;
    logic [8:0] taps;

    assign slot_free  = !out_valid_q || out_ready_i;
    assign in_fire    = (state_q == S_RUN) && in_valid_i && slot_free;
    assign flush_fire = (state_q == S_FLUSH) && (flush_q != FILL_N) && slot_free;
    assign push       = in_fire || flush_fire;
    assign primed     = (fill_q == FILL_N);
    assign out_hs     = out_valid_q && out_ready_i;
    assign new_bit    = in_fire && (in_data_i >= thr_q);
    // Flat shift register: bit i holds the pixel pushed i steps ago, so the
    // three window rows sit at offsets 0, IMG_W and 2*IMG_W.
    assign win_d      = {win_q, new_bit};

    always_comb begin
        up = (row_q != '0);
        dn = (row_q != ROW_LAST);
        lf = (col_q != '0);
        rt = (col_q != COL_LAST);
        taps[0] = win_d[0]         & dn & rt;
        taps[1] = win_d[1]         & dn;
        taps[2] = win_d[2]         & dn & lf;
        taps[3] = win_d[IMG_W]     & rt;
        taps[4] = win_d[IMG_W+1];
        taps[5] = win_d[IMG_W+2]   & lf;
        taps[6] = win_d[2*IMG_W]   & up & rt;
        taps[7] = win_d[2*IMG_W+1] & up;
        taps[8] = win_d[2*IMG_W+2] & up & lf;
        ero = &taps;
        dil = |taps;
        bw  = taps[4];
        unique case (mode_q)
            2'd0:    res = ero;
            2'd1:    res = dil;
            2'd2:    res = bw & ~ero;
            default: res = dil & ~bw;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (in_fire && (in_cnt_q == N_LAST)) state_d = S_FLUSH;
            S_FLUSH: if (out_hs && (pix_cnt_q == N_LAST)) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            thr_q       <= '0;
            mode_q      <= '0;
            win_q       <= '0;
            fill_q      <= '0;
            flush_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            in_cnt_q    <= '0;
            pix_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if ((state_q == S_IDLE) && start_i) begin
                thr_q     <= thr_i;
                mode_q    <= mode_i;
                win_q     <= '0;
                fill_q    <= '0;
                flush_q   <= '0;
                col_q     <= '0;
                row_q     <= '0;
                in_cnt_q  <= '0;
                pix_cnt_q <= '0;
            end
            if (in_fire)    in_cnt_q <= in_cnt_q + 1'b1;
            if (flush_fire) flush_q  <= flush_q + 1'b1;
            if (push) begin
                win_q <= win_d[SRL-2:0];
                if (!primed) begin
                    fill_q <= fill_q + 1'b1;
                end else if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
            if (push && primed) begin
                out_valid_q <= 1'b1;
                out_data_q  <= {8{res}};
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
            end
            if (out_hs) pix_cnt_q <= pix_cnt_q + 1'b1;
        end
    end

    assign in_ready_o   = (state_q == S_RUN) && slot_free;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign busy_o       = (state_q != S_IDLE);
    assign frame_done_o = (state_q == S_DONE);
    assign state_o      = state_q;
    assign pix_cnt_o    = pix_cnt_q;

endmodule

// File: tb/tb_morph_edge_stream.sv
// Self-checking bench for morph_edge_stream on an 8x4 image: directed frames
// checked against a neighbourhood model, plus stall and reset scenarios.
module tb_morph_edge_stream;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int NPIX = W*H;

    logic       clk, rst_n, start_i, in_valid_i, in_ready_o, out_valid_o;
    logic       out_ready_i, busy_o, frame_done_o;
    logic [7:0] thr_i, in_data_i, out_data_o;
    logic [1:0] mode_i;
    logic [2:0] state_o;
    logic [5:0] pix_cnt_o;

    int checks = 0;
    int failures = 0;

    logic [7:0] img   [NPIX];
    logic [7:0] exp_q [NPIX];
    logic [7:0] got_q [NPIX];
    int  out_idx = 0;
    int  done_cnt = 0;
    bit  prev_stall = 0;
    bit  last_prev = 0;
    logic [7:0] prev_data = '0;

    morph_edge_stream #(.IMG_W(W), .IMG_H(H), .CW(6)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .thr_i(thr_i),
        .mode_i(mode_i), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
        .in_ready_o(in_ready_o), .out_valid_o(out_valid_o),
        .out_data_o(out_data_o), .out_ready_i(out_ready_i), .busy_o(busy_o),
        .frame_done_o(frame_done_o), .state_o(state_o), .pix_cnt_o(pix_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, want);
        end
    endtask

    // Reference: threshold to a binary image, then evaluate every 3x3
    // neighbourhood directly with out-of-image neighbours treated as 0.
    function automatic void build_model(input logic [1:0] mode, input logic [7:0] thr);
        bit b [H][W];
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                b[r][c] = (img[r*W+c] >= thr);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                bit ero, dil, res;
                ero = 1'b1;
                dil = 1'b0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr, cc;
                        bit v;
                        rr = r + dr;
                        cc = c + dc;
                        v = (rr >= 0 && rr < H && cc >= 0 && cc < W) ? b[rr][cc] : 1'b0;
                        ero &= v;
                        dil |= v;
                    end
                end
                case (mode)
                    2'd0:    res = ero;
                    2'd1:    res = dil;
                    2'd2:    res = b[r][c] & ~ero;
                    default: res = dil & ~b[r][c];
                endcase
                exp_q[r*W+c] = res ? 8'hFF : 8'h00;
            end
        end
    endfunction

    function automatic int count_ff();
        int n = 0;
        for (int i = 0; i < NPIX; i++) if (got_q[i] == 8'hFF) n++;
        return n;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            last_prev  = 1'b0;
        end else begin
            if (start_i && state_o == 3'd0) begin
                out_idx    = 0;
                done_cnt   = 0;
                prev_stall = 1'b0;
                last_prev  = 1'b0;
                for (int i = 0; i < NPIX; i++) got_q[i] = 8'h5A;
            end
            if (prev_stall) begin
                check_eq("hold_valid", 32'(out_valid_o), 32'd1);
                check_eq("hold_data", 32'(out_data_o), 32'(prev_data));
            end
            if (busy_o) check_eq("pix_cnt", 32'(pix_cnt_o), 32'(out_idx));
            if (frame_done_o) begin
                done_cnt++;
                check_eq("done_after_last", 32'(last_prev), 32'd1);
            end
            last_prev = 1'b0;
            if (out_valid_o && out_ready_i) begin
                if (out_idx < NPIX) begin
                    check_eq($sformatf("pix%0d", out_idx), 32'(out_data_o), 32'(exp_q[out_idx]));
                    got_q[out_idx] = out_data_o;
                end else begin
                    checks++;
                    failures++;
                    $display("FAIL extra_output got=%0d outputs expected=%0d", out_idx + 1, NPIX);
                end
                out_idx++;
                last_prev = (out_idx == NPIX);
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_data  = out_data_o;
        end
    end

    task automatic run_frame(input logic [1:0] mode, input logic [7:0] thr, input bit stalls, input bit lat_chk);
        int acc = 0;
        int cyc = 0;
        bit vhold = 1'b0;
        build_model(mode, thr);
        @(posedge clk); #1;
        mode_i = mode; thr_i = thr; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        while (acc < NPIX && cyc < 2000) begin
            in_valid_i  = stalls ? (vhold || $urandom_range(0, 3) != 0) : 1'b1;
            in_data_i   = img[acc];
            out_ready_i = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
            start_i     = stalls && (cyc == 7);
            @(negedge clk);
            if (lat_chk) check_eq("latency_valid", 32'(out_valid_o), 32'(acc >= W + 2));
            if (in_valid_i && in_ready_o) begin
                acc++;
                vhold = 1'b0;
            end else begin
                vhold = in_valid_i;
            end
            cyc++;
            @(posedge clk); #1;
        end
        check_eq("inputs_accepted", 32'(acc), 32'(NPIX));
        in_valid_i = 1'b0;
        start_i    = 1'b0;
        while (done_cnt == 0 && cyc < 4000) begin
            out_ready_i = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            cyc++;
            @(posedge clk); #1;
        end
        out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("done_pulses", 32'(done_cnt), 32'd1);
        check_eq("output_count", 32'(out_idx), 32'(NPIX));
        check_eq("idle_busy", 32'(busy_o), 32'd0);
        check_eq("idle_state", 32'(state_o), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_in_ready"}, 32'(in_ready_o), 32'd0);
        check_eq({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
        check_eq({tag, "_out_data"}, 32'(out_data_o), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
        check_eq({tag, "_frame_done"}, 32'(frame_done_o), 32'd0);
        check_eq({tag, "_state"}, 32'(state_o), 32'd0);
        check_eq({tag, "_pix_cnt"}, 32'(pix_cnt_o), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, cyc;
        rst_n = 1'b0; start_i = 1'b0; thr_i = '0; mode_i = '0;
        in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < NPIX; i++) img[i] = 8'd255;
        run_frame(2'd0, 8'd140, 1'b0, 1'b1);
        check_eq("ero_ff_count", 32'(count_ff()), 32'd12);
        check_eq("ero_interior", 32'(got_q[9]), 32'hFF);
        check_eq("ero_corner", 32'(got_q[0]), 32'h00);
        check_eq("ero_right_edge", 32'(got_q[15]), 32'h00);
        run_frame(2'd1, 8'd140, 1'b0, 1'b0);
        check_eq("dil_ff_count", 32'(count_ff()), 32'd32);
        run_frame(2'd2, 8'd140, 1'b0, 1'b0);
        check_eq("igrad_ff_count", 32'(count_ff()), 32'd20);
        check_eq("igrad_border", 32'(got_q[24]), 32'hFF);
        check_eq("igrad_interior", 32'(got_q[10]), 32'h00);
        run_frame(2'd3, 8'd140, 1'b0, 1'b0);
        check_eq("egrad_ff_count", 32'(count_ff()), 32'd0);

        for (int i = 0; i < NPIX; i++) img[i] = 8'd0;
        img[1*W+3] = 8'd200;
        run_frame(2'd1, 8'd140, 1'b0, 1'b0);
        check_eq("dot_dil_count", 32'(count_ff()), 32'd9);
        check_eq("dot_dil_r0c2", 32'(got_q[2]), 32'hFF);
        check_eq("dot_dil_r2c4", 32'(got_q[2*W+4]), 32'hFF);
        check_eq("dot_dil_r2c5", 32'(got_q[2*W+5]), 32'h00);
        check_eq("dot_dil_r3c3", 32'(got_q[3*W+3]), 32'h00);
        run_frame(2'd0, 8'd140, 1'b0, 1'b0);
        check_eq("dot_ero_count", 32'(count_ff()), 32'd0);

        for (int i = 0; i < NPIX; i++) img[i] = 8'd140;
        run_frame(2'd1, 8'd140, 1'b0, 1'b0);
        check_eq("thr_equal_count", 32'(count_ff()), 32'd32);
        for (int i = 0; i < NPIX; i++) img[i] = 8'd139;
        run_frame(2'd1, 8'd140, 1'b0, 1'b0);
        check_eq("thr_below_count", 32'(count_ff()), 32'd0);

        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
        run_frame(2'd2, 8'd128, 1'b1, 1'b0);
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
        run_frame(2'd3, 8'd100, 1'b1, 1'b0);

        // Abort a frame mid-RUN with an asynchronous reset.
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
        build_model(2'd1, 8'd128);
        @(posedge clk); #1;
        mode_i = 2'd1; thr_i = 8'd128; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        acc = 0;
        cyc = 0;
        in_valid_i = 1'b1;
        out_ready_i = 1'b1;
        while (acc < 10 && cyc < 100) begin
            in_data_i = img[acc];
            @(negedge clk);
            if (in_ready_o) acc++;
            cyc++;
            @(posedge clk); #1;
        end
        check_eq("abort_accepted", 32'(acc), 32'd10);
        check_eq("abort_pre_busy", 32'(busy_o), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        in_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
        run_frame(2'd1, 8'd128, 1'b1, 1'b0);
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
        run_frame(2'd0, 8'd60, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/morph_edge_stream.md
Name: morph_edge_stream

Overview:
- Streaming successor to the frame-buffered threshold/erosion/subtract pipeline.
- Thresholds 8-bit grey pixels to binary and applies a 3x3 morphological operator using two 1-bit line buffers, with no full-frame RAM.
- Emits one 8-bit result per input pixel in raster order.
- Image size, operator mode and threshold are configurable; valid/ready handshakes on both sides; sits between the camera/UART pixel source and the result sink.

Parameters:
- IMG_W, 320, pixels per row (≥3)
- IMG_H, 240, rows per frame (≥2)
- CW, 17, width of pixel counter; must satisfy 2^CW ≥ IMG_W*IMG_H

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse; samples thr_i and mode_i, starts a frame (ignored unless IDLE)
- thr_i  in  8  threshold; pixel ≥ thr_i → 1 (255), else 0
- mode_i  in  2  0 erosion, 1 dilation, 2 internal gradient (bw AND NOT ero), 3 external gradient (dil AND NOT bw)
- in_valid_i  in  1  input pixel valid
- in_data_i  in  8  grey pixel
- in_ready_o  out  1  block accepts pixel this cycle
- out_valid_o  out  1  result valid
- out_data_o  out  8  result, 8'h00 or 8'hFF
- out_ready_i  in  1  sink accepts result
- busy_o  out  1  high outside IDLE
- frame_done_o  out  1  one-cycle pulse after last output handshake
- state_o  out  3  current FSM state, debug
- pix_cnt_o  out  CW  outputs emitted in current frame

Behaviour:
- Reset (rst_ni low, async, any time incl. mid-frame): state IDLE; all counters, line buffers, window regs cleared.
  - All outputs 0: in_ready_o, out_valid_o, out_data_o, busy_o, frame_done_o, state_o, pix_cnt_o.
  - Partial frame discarded.
- States: IDLE(0), RUN(1), FLUSH(2), DONE(3).
- IDLE → RUN on start_i; latch thr/mode; clear counters and line buffers.
- Input handshake: transfer when in_valid_i && in_ready_o. in_ready_o = (state==RUN) && (!out_valid_o || out_ready_i).
- Each accepted pixel is thresholded to 1 bit and shifted into the window; line buffers delay by IMG_W.
- Window centre lags the newest input by IMG_W+1 pixels.
  - No output for the first IMG_W+1 inputs.
  - Thereafter each accepted input produces exactly one output for centre (r,c).
- Borders: neighbours outside the image are 0, including wrap across row ends; column counters mask them.
  - Erosion at any border pixel is therefore 0.
- ero = AND of 9 taps; dil = OR of 9 taps; bw = centre tap. Result bit b → out_data_o = {8{b}}.
- RUN → FLUSH after the IMG_W*IMG_H-th accepted input.
- FLUSH: in_ready_o=0; block injects IMG_W+1 virtual zero pixels, one per cycle when !out_valid_o || out_ready_i, each producing one output.
- Output register: out_valid_o/out_data_o hold stable while out_valid_o && !out_ready_i; new result loaded only on free slot.
- pix_cnt_o increments on each output handshake.
- When pix_cnt reaches IMG_W*IMG_H (last handshake): → DONE; frame_done_o=1 for one cycle; then → IDLE.
- start_i in RUN/FLUSH/DONE ignored.
- in_valid_i while not ready: pixel held by source; no loss or duplication.
- Total outputs per frame exactly IMG_W*IMG_H regardless of stall pattern.
- Latency with no stalls: output k appears one cycle after accept of input k+IMG_W+1.

Test Plan (IMG_W=8, IMG_H=4 unless stated):
- All-255 input, thr=140, mode 0 → 32 outputs; rows 1..2, cols 1..6 = FF; all border pixels 00; frame_done_o one pulse after 32nd handshake.
- Same frame, mode 1 → all 32 outputs FF; mode 2 → border FF, interior 00; mode 3 → all 00.
- Single pixel 200 at (1,3), rest 0, thr=140: mode 1 → FF at rows 0..2, cols 2..4 (9 pixels), else 00; mode 0 → all 00.
- Threshold boundary: uniform pixel 140 with thr=140 → treated as 1; uniform pixel 139 → treated as 0; checked in mode 1.
- Random out_ready_i (50%) and in_valid_i gaps, random image → output stream bit-exact to reference model; out_data_o stable during stalls; exactly 32 outputs.
- rst_ni low mid-RUN after 10 inputs → outputs 0 immediately; new start_i with a fresh frame gives correct results with no residue from the aborted frame.
